// File: rtl/snn_apb_regs.sv
// APB3 completer register block for the SNN core: leak/run control, 64-pixel frame, spike live/sticky/counter readback.
// Build option: define SNN_APB_PSLVERR_EN to add the pslverr output for unmapped, read-only-write or misaligned accesses.
module snn_apb_regs #(
    parameter int INPUT_SIZE  = 64,
    parameter int OUTPUT_SIZE = 16,
    parameter int PIXEL_WIDTH = 8,
    parameter int WAIT_STATES = 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [7:0]                        paddr,
    input  logic                              psel,
    input  logic                              penable,
    input  logic                              pwrite,
    input  logic [31:0]                       pwdata,
    output logic [31:0]                       prdata,
    output logic                              pready,
`ifdef SNN_APB_PSLVERR_EN
    output logic                              pslverr,
`endif
    output logic [INPUT_SIZE*PIXEL_WIDTH-1:0] pixel_input,
    output logic [7:0]                        leak_factor,
    output logic                              snn_run,
    input  logic [OUTPUT_SIZE-1:0]            digit_spikes
);

    localparam int NWORDS = INPUT_SIZE / 4;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t                   state, state_nx;
    logic [2:0]               wcnt, wcnt_nx;
    logic                     pready_nx;
    logic [31:0]              prdata_nx;
    logic [31:0]              rd_data;
    logic [5:0]               widx;
    logic                     setup_ph, access_ph;
    logic                     access_err;
    logic                     wr_en, clr_cnt;
    logic [OUTPUT_SIZE-1:0]   spike_q, sticky, w1c;
    logic [15:0]              cnt [OUTPUT_SIZE];

    assign widx = paddr[7:2];

`ifdef SNN_APB_PSLVERR_EN
    logic mapped, ro;
    always_comb begin
        mapped     = (widx[5:2] == 4'd0) || (widx[5:4] == 2'b01) || (widx[5:4] == 2'b10);
        ro         = (widx == 6'd1) || (widx == 6'd2) || (widx[5:4] == 2'b10);
        access_err = !mapped || (pwrite && ro) || (paddr[1:0] != 2'b00);
    end
`else
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^paddr[1:0];
    assign access_err      = 1'b0;
`endif

    assign wr_en   = psel && penable && pready && pwrite && !access_err;
    assign clr_cnt = wr_en && (widx == 6'd0) && pwdata[9];
    assign w1c     = (wr_en && (widx == 6'd3)) ? pwdata[OUTPUT_SIZE-1:0] : '0;

    always_comb begin
        rd_data = '0;
        case (widx)
            6'd0:    rd_data[8:0] = {snn_run, leak_factor};
            6'd1:    rd_data[1:0] = {|sticky, snn_run};
            6'd2:    rd_data[OUTPUT_SIZE-1:0] = spike_q;
            6'd3:    rd_data[OUTPUT_SIZE-1:0] = sticky;
            default: rd_data = '0;
        endcase
        for (int j = 0; j < NWORDS; j++)
            if (int'(widx) == 16 + j) rd_data = pixel_input[32*j +: 32];
        for (int k = 0; k < OUTPUT_SIZE; k++)
            if (int'(widx) == 32 + k) rd_data = {16'h0000, cnt[k]};
    end

    // pready/prdata are registered, so completion is predicted one cycle ahead:
    // the setup cycle or the last wait cycle arms them for the following cycle.
    always_comb begin
        setup_ph  = psel && !penable;
        access_ph = psel && penable && !pready && (state != IDLE);
        state_nx  = IDLE;
        wcnt_nx   = wcnt;
        pready_nx = 1'b0;
        if (setup_ph) begin
            state_nx  = SETUP;
            wcnt_nx   = 3'(WAIT_STATES);
            pready_nx = (WAIT_STATES == 0);
        end else if (access_ph) begin
            state_nx  = ACCESS;
            wcnt_nx   = wcnt - 3'd1;
            pready_nx = (wcnt == 3'd1);
        end
        prdata_nx = (pready_nx && !pwrite) ? rd_data : 32'h0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            wcnt    <= '0;
            pready  <= 1'b0;
            prdata  <= '0;
`ifdef SNN_APB_PSLVERR_EN
            pslverr <= 1'b0;
`endif
        end else begin
            state   <= state_nx;
            wcnt    <= wcnt_nx;
            pready  <= pready_nx;
            prdata  <= prdata_nx;
`ifdef SNN_APB_PSLVERR_EN
            pslverr <= pready_nx && access_err;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            leak_factor <= '0;
            snn_run     <= 1'b0;
            pixel_input <= '0;
        end else if (wr_en) begin
            if (widx == 6'd0) begin
                leak_factor <= pwdata[7:0];
                snn_run     <= pwdata[8];
            end
            for (int j = 0; j < NWORDS; j++)
                if (int'(widx) == 16 + j) pixel_input[32*j +: 32] <= pwdata;
        end
    end

    // A new spike beats a same-cycle W1C; a clear beats a same-cycle increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            spike_q <= '0;
            sticky  <= '0;
            for (int k = 0; k < OUTPUT_SIZE; k++) cnt[k] <= '0;
        end else begin
            spike_q <= digit_spikes;
            sticky  <= (sticky & ~w1c) | (digit_spikes & {OUTPUT_SIZE{snn_run}});
            for (int k = 0; k < OUTPUT_SIZE; k++) begin
                if (clr_cnt)
                    cnt[k] <= '0;
                else if (snn_run && digit_spikes[k] && (cnt[k] != 16'hFFFF))
                    cnt[k] <= cnt[k] + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_snn_apb_regs.sv
// Directed bench for snn_apb_regs: APB timing, register map, spike counters and sticky bits.
module tb_snn_apb_regs;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [7:0]   paddr = '0;
    logic         psel = 1'b0;
    logic         penable = 1'b0;
    logic         pwrite = 1'b0;
    logic [31:0]  pwdata = '0;
    logic [31:0]  prdata;
    logic         pready;
    logic [511:0] pixel_input;
    logic [7:0]   leak_factor;
    logic         snn_run;
    logic [15:0]  digit_spikes = '0;
`ifdef SNN_APB_PSLVERR_EN
    logic         pslverr;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] rdv;
    int          wv;
    logic        ev;

    always #5 clk = ~clk;

    snn_apb_regs dut (
        .clk          (clk),
        .rst          (rst),
        .paddr        (paddr),
        .psel         (psel),
        .penable      (penable),
        .pwrite       (pwrite),
        .pwdata       (pwdata),
        .prdata       (prdata),
        .pready       (pready),
`ifdef SNN_APB_PSLVERR_EN
        .pslverr      (pslverr),
`endif
        .pixel_input  (pixel_input),
        .leak_factor  (leak_factor),
        .snn_run      (snn_run),
        .digit_spikes (digit_spikes)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic apb(input logic [7:0] a, input logic w, input logic [31:0] d,
                       output logic [31:0] rd, output int waits, output logic err);
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; paddr = a; pwrite = w; pwdata = d;
        @(posedge clk); #1;
        penable = 1'b1;
        waits = 0;
        @(negedge clk);
        while (!pready && waits < 16) begin
            waits++;
            @(negedge clk);
        end
        chk("apb_complete", {31'b0, pready}, 32'd1);
        rd = prdata;
`ifdef SNN_APB_PSLVERR_EN
        err = pslverr;
`else
        err = 1'b0;
`endif
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        apb(a, 1'b1, d, rdv, wv, ev);
    endtask

    task automatic rd_chk(input string tag, input logic [7:0] a, input logic [31:0] exp);
        apb(a, 1'b0, 32'h0, rdv, wv, ev);
        chk(tag, rdv, exp);
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_pready", {31'b0, pready}, 32'd0);
        chk("rst_prdata", prdata, 32'd0);
        chk("rst_pixels", {31'b0, |pixel_input}, 32'd0);
        chk("rst_leak", {24'b0, leak_factor}, 32'd0);
        chk("rst_run", {31'b0, snn_run}, 32'd0);
        rst = 1'b0;

        // Reset during ACCESS drops the pending CTRL write
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; paddr = 8'h00; pwrite = 1'b1; pwdata = 32'h1FF;
        @(posedge clk); #1;
        penable = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_pready", {31'b0, pready}, 32'd0);
        chk("midrst_prdata", prdata, 32'd0);
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_leak", {24'b0, leak_factor}, 32'd0);
        chk("midrst_run", {31'b0, snn_run}, 32'd0);
        rd_chk("midrst_ctrl_rd", 8'h00, 32'h0);

        // CTRL write with one wait state
        wr(8'h00, 32'h1A5);
        chk("ctrl_waits", wv, 32'd1);
        chk("ctrl_leak", {24'b0, leak_factor}, 32'hA5);
        chk("ctrl_run", {31'b0, snn_run}, 32'd1);
        @(negedge clk);
        chk("pready_one_cycle", {31'b0, pready}, 32'd0);
        rd_chk("ctrl_rd", 8'h00, 32'h1A5);
        chk("rd_waits", wv, 32'd1);
        rd_chk("status_run", 8'h04, 32'h1);

        // Pixel words
        wr(8'h44, 32'h04030201);
        chk("pix4", {24'b0, pixel_input[39:32]}, 32'h01);
        chk("pix7", {24'b0, pixel_input[63:56]}, 32'h04);
        rd_chk("pix_rd", 8'h44, 32'h04030201);
        rd_chk("pix0_rd", 8'h40, 32'h0);
        wr(8'h7C, 32'hDEADBEEF);
        chk("pix_last", pixel_input[511:480], 32'hDEADBEEF);

        // Five spikes on output 3 while running
        @(posedge clk); #1;
        digit_spikes = 16'h0008;
        repeat (5) @(posedge clk);
        #1;
        digit_spikes = 16'h0000;
        rd_chk("cnt3", 8'h8C, 32'd5);
        rd_chk("sticky3", 8'h0C, 32'h0008);
        rd_chk("status_sticky", 8'h04, 32'h3);
        wr(8'h0C, 32'h0008);
        rd_chk("sticky_w1c", 8'h0C, 32'h0);

        // Counter saturation, then CLR_CNT coincident with a spike
        digit_spikes = 16'h0001;
        repeat (70000) @(posedge clk);
        rd_chk("cnt0_sat", 8'h80, 32'h0000FFFF);
        wr(8'h00, 32'h3A5);
        digit_spikes = 16'h0000;
        rd_chk("cnt0_clr", 8'h80, 32'h0);
        rd_chk("cnt3_clr", 8'h8C, 32'h0);
        rd_chk("ctrl_clr_reads0", 8'h00, 32'h1A5);

        // Stopped network ignores spikes
        wr(8'h00, 32'h0A5);
        chk("run_off", {31'b0, snn_run}, 32'd0);
        @(posedge clk); #1;
        digit_spikes = 16'h0002;
        repeat (3) @(posedge clk);
        #1;
        digit_spikes = 16'h0000;
        rd_chk("cnt1_stopped", 8'h84, 32'h0);
        rd_chk("sticky_stopped", 8'h0C, 32'h0001);
        rd_chk("status_stopped", 8'h04, 32'h2);
        wr(8'h0C, 32'hFFFF);
        rd_chk("sticky_all_clr", 8'h0C, 32'h0);

        // Unmapped accesses
        apb(8'hF0, 1'b0, 32'h0, rdv, wv, ev);
        chk("unmapped_rd", rdv, 32'h0);
        chk("unmapped_waits", wv, 32'd1);
`ifdef SNN_APB_PSLVERR_EN
        chk("unmapped_err", {31'b0, ev}, 32'd1);
        apb(8'h00, 1'b0, 32'h0, rdv, wv, ev);
        chk("mapped_no_err", {31'b0, ev}, 32'd0);
`endif
        wr(8'hF0, 32'hFFFFFFFF);
        rd_chk("ctrl_after_unmapped", 8'h00, 32'h0A5);

        // Live spike register
        digit_spikes = 16'h0120;
        rd_chk("spike_live", 8'h08, 32'h0120);
        digit_spikes = 16'h0000;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
